// File: rtl/vga_raster_scanner.sv
// vga_raster_scanner: 640x480 VGA raster timing with 1-based pixel coordinates and registered sync/DE/RGB.
// Define VGA_FRAME_TICK_EN to generate frame_tick; otherwise frame_tick is tied to 0.
module vga_raster_scanner #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        CLOCK_25,
    input  logic        reset_n,
    output logic [11:0] x,
    output logic [11:0] y,
    input  logic [2:0]  color,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [2:0]  vga_rgb,
    output logic        vga_de,
    output logic        frame_tick
);
    localparam logic [11:0] HA     = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA     = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [1:0]  rst_sync_q;
    logic        rst_sync_n;
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        active, hsync_d, vsync_d;
    logic        hsync_q, vsync_q, de_q;
    logic [2:0]  rgb_q;

    // Reset asserts immediately but releases two edges later to avoid metastable deassertion.
    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_sync_n = rst_sync_q[1];

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        active  = (h_cnt_q < HA) && (v_cnt_q < VA);
        x       = active ? h_cnt_q + 12'd1 : 12'd0;
        y       = active ? v_cnt_q + 12'd1 : 12'd0;
        hsync_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vsync_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    end

    always_ff @(posedge CLOCK_25 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= 3'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= active;
            rgb_q   <= active ? color : 3'd0;
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_de    = de_q;
    assign vga_rgb   = rgb_q;

`ifdef VGA_FRAME_TICK_EN
    logic tick_q;

    // Counter at (H_ACTIVE, V_ACTIVE-1) means the outputs show the first blanking pixel next edge.
    always_ff @(posedge CLOCK_25 or negedge rst_sync_n) begin
        if (!rst_sync_n) tick_q <= 1'b0;
        else             tick_q <= (h_cnt_q == HA) && (v_cnt_q == VA - 12'd1);
    end

    assign frame_tick = tick_q;
`else
    assign frame_tick = 1'b0;
`endif
endmodule
